// File: rtl/cmac_tx_pkt_arbiter.sv
// cmac_tx_pkt_arbiter
//   Packet-atomic 2:1 round-robin arbiter in front of the CMAC 100G TX
//   AXI-Stream input. A requester is granted only while the link is up and
//   keeps the grant until its tlast handshake. A watchdog cuts packets longer
//   than P_MAX_BEATS: the cut beat goes out with tlast=1/tuser=1 so the CMAC
//   aborts the frame, and the rest of that packet is discarded.
//
// Ports
//   i_clk, i_rst_n     CMAC tx user clock, synchronous active-low reset
//   i_stat_rx_status   link up; gates new grants only
//   s0_axis_*          requester 0 AXIS slave (tvalid/tready/tdata/tkeep/tlast/tuser)
//   s1_axis_*          requester 1 AXIS slave
//   m_axis_*           AXIS master towards CMAC TX
//   o_busy             a packet is in flight (state != IDLE)
//   o_trunc_pulse      one-cycle pulse, bit per channel, on watchdog truncation
//
// Optional build macro CMAC_TX_ARB_STATS_EN adds:
//   o_pkt_cnt0/1       completed packets forwarded per channel (wrapping)
//   o_drop_beats       beats discarded after truncation (wrapping)
module cmac_tx_pkt_arbiter #(
  parameter int P_DATA_W    = 512,
  parameter int P_KEEP_W    = 64,
  parameter int P_MAX_BEATS = 160
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stat_rx_status,
  input  logic                s0_axis_tvalid,
  output logic                s0_axis_tready,
  input  logic [P_DATA_W-1:0] s0_axis_tdata,
  input  logic [P_KEEP_W-1:0] s0_axis_tkeep,
  input  logic                s0_axis_tlast,
  input  logic                s0_axis_tuser,
  input  logic                s1_axis_tvalid,
  output logic                s1_axis_tready,
  input  logic [P_DATA_W-1:0] s1_axis_tdata,
  input  logic [P_KEEP_W-1:0] s1_axis_tkeep,
  input  logic                s1_axis_tlast,
  input  logic                s1_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [P_DATA_W-1:0] m_axis_tdata,
  output logic [P_KEEP_W-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                o_busy,
  output logic [1:0]          o_trunc_pulse
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [31:0]         o_pkt_cnt0,
  output logic [31:0]         o_pkt_cnt1,
  output logic [31:0]         o_drop_beats
`endif
);

  localparam int CNT_W = $clog2(P_MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DROP
  } state_t;

  state_t           state, state_nxt;
  logic             g, g_nxt;
  logic             lp, lp_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic                sel_valid, sel_last, sel_user, sel_ready, fwd, wdog;
  logic [P_DATA_W-1:0] sel_data;
  logic [P_KEEP_W-1:0] sel_keep;

  // Granted requester's fields.
  assign sel_valid = g ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_data  = g ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_keep  = g ? s1_axis_tkeep  : s0_axis_tkeep;
  assign sel_last  = g ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_user  = g ? s1_axis_tuser  : s0_axis_tuser;

  // Last permitted beat of a packet that has not ended on its own.
  assign wdog = (cnt == CNT_LAST) && !sel_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      g     <= 1'b0;
      lp    <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      lp    <= lp_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    lp_nxt        = lp;
    cnt_nxt       = cnt;
    sel_ready     = 1'b0;
    fwd           = 1'b0;
    o_trunc_pulse = '0;
    case (state)
      IDLE: begin
        if (i_stat_rx_status && (s0_axis_tvalid || s1_axis_tvalid)) begin
          state_nxt = GRANT;
          cnt_nxt   = '0;
          if (s0_axis_tvalid && s1_axis_tvalid) g_nxt = ~lp;
          else                                  g_nxt = s1_axis_tvalid;
        end
      end
      GRANT: begin
        fwd       = 1'b1;
        sel_ready = m_axis_tready;
        if (sel_valid && m_axis_tready) begin
          if (cnt != '1) cnt_nxt = cnt + 1'b1;
          if (wdog) begin
            o_trunc_pulse[g] = 1'b1;
            state_nxt        = DROP;
          end else if (sel_last) begin
            state_nxt = IDLE;
            lp_nxt    = g;
          end
        end
      end
      DROP: begin
        sel_ready = 1'b1;
        if (sel_valid && sel_last) begin
          state_nxt = IDLE;
          lp_nxt    = g;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to zero outside GRANT so idle/drop cycles show a clean bus.
  assign m_axis_tvalid  = fwd && sel_valid;
  assign m_axis_tdata   = fwd ? sel_data : '0;
  assign m_axis_tkeep   = fwd ? sel_keep : '0;
  assign m_axis_tlast   = fwd && (sel_last || wdog);
  assign m_axis_tuser   = fwd && (sel_user || wdog);
  assign s0_axis_tready = sel_ready && !g;
  assign s1_axis_tready = sel_ready && g;
  assign o_busy         = (state != IDLE);

`ifdef CMAC_TX_ARB_STATS_EN
  logic pkt_done, drop_beat;

  // m_axis_tlast already includes the watchdog cut, so truncated packets count.
  assign pkt_done  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign drop_beat = (state == DROP) && sel_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pkt_cnt0   <= '0;
      o_pkt_cnt1   <= '0;
      o_drop_beats <= '0;
    end else begin
      if (pkt_done && !g) o_pkt_cnt0 <= o_pkt_cnt0 + 32'd1;
      if (pkt_done && g)  o_pkt_cnt1 <= o_pkt_cnt1 + 32'd1;
      if (drop_beat)      o_drop_beats <= o_drop_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmac_tx_pkt_arbiter.sv
// Testbench for cmac_tx_pkt_arbiter (P_MAX_BEATS=8). Stimulus builds packets
// per channel, a packet-level round-robin model pushes expected output beats
// into a scoreboard, and a monitor pops/compares on every m_axis handshake.
module tb_cmac_tx_pkt_arbiter;
  localparam int DW   = 512;
  localparam int KW   = 64;
  localparam int MAXB = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic          first;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  ch;
    logic  trunc;
    logic  last;
    logic  user;
  } exp_t;

  logic          clk, rst_n, link;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
  logic [DW-1:0] s0_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
  logic [DW-1:0] s1_axis_tdata;
  logic [KW-1:0] s1_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          o_busy;
  logic [1:0]    o_trunc_pulse;
`ifdef CMAC_TX_ARB_STATS_EN
  logic [31:0]   o_pkt_cnt0, o_pkt_cnt1, o_drop_beats;
`endif

  cmac_tx_pkt_arbiter #(
    .P_DATA_W   (DW),
    .P_KEEP_W   (KW),
    .P_MAX_BEATS(MAXB)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stat_rx_status(link),
    .s0_axis_tvalid  (s0_axis_tvalid),
    .s0_axis_tready  (s0_axis_tready),
    .s0_axis_tdata   (s0_axis_tdata),
    .s0_axis_tkeep   (s0_axis_tkeep),
    .s0_axis_tlast   (s0_axis_tlast),
    .s0_axis_tuser   (s0_axis_tuser),
    .s1_axis_tvalid  (s1_axis_tvalid),
    .s1_axis_tready  (s1_axis_tready),
    .s1_axis_tdata   (s1_axis_tdata),
    .s1_axis_tkeep   (s1_axis_tkeep),
    .s1_axis_tlast   (s1_axis_tlast),
    .s1_axis_tuser   (s1_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .o_busy          (o_busy),
    .o_trunc_pulse   (o_trunc_pulse)
`ifdef CMAC_TX_ARB_STATS_EN
    ,
    .o_pkt_cnt0      (o_pkt_cnt0),
    .o_pkt_cnt1      (o_pkt_cnt1),
    .o_drop_beats    (o_drop_beats)
`endif
  );

  // Scoreboard / driver state
  beat_t drv_q0[$];
  beat_t drv_q1[$];
  exp_t  exp_q[$];
  int    pl0[$];
  int    pl1[$];
  int    m_lp;
  int    m_pkt0, m_pkt1, m_drop;
  int    vectors, errors;
  int    rdy_mode;
  bit    gaps_en, chk_reset, chk_idle, chk_gap, chk_stats, tmo_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One packet: driver beats plus the beats the arbiter should emit.
  task automatic gen_pkt(input int ch, input int len);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < len; k++) begin
      b.data  = rnd_data();
      b.last  = (k == len - 1);
      b.first = (k == 0);
      b.keep  = b.last ? ({KW{1'b1}} >> $urandom_range(0, KW - 1)) : {KW{1'b1}};
      b.user  = ($urandom_range(0, 7) == 0);
      if (ch == 1) drv_q1.push_back(b);
      else         drv_q0.push_back(b);
      if (k < MAXB) begin
        e.b     = b;
        e.ch    = (ch == 1);
        e.trunc = (k == MAXB - 1) && (len > MAXB);
        e.last  = b.last || e.trunc;
        e.user  = b.user || e.trunc;
        exp_q.push_back(e);
      end else begin
        m_drop++;
      end
    end
    if (ch == 1) m_pkt1++;
    else         m_pkt0++;
  endtask

  // Packet-level round robin: alternate while both channels have work,
  // starting with the channel not served last.
  task automatic build();
    int i0, i1, ch, len;
    i0 = 0;
    i1 = 0;
    while (i0 < pl0.size() || i1 < pl1.size()) begin
      if (i0 < pl0.size() && i1 < pl1.size()) ch = 1 - m_lp;
      else ch = (i0 < pl0.size()) ? 0 : 1;
      if (ch == 1) begin len = pl1[i1]; i1++; end
      else         begin len = pl0[i0]; i0++; end
      gen_pkt(ch, len);
      m_lp = ch;
    end
    pl0.delete();
    pl1.delete();
  endtask

  // Requester drivers: first beat of a packet is presented without delay,
  // later beats may be preceded by random bubbles.
  initial begin
    logic hs0, hs1;
    int   gap0, gap1;
    gap0 = 0;
    gap1 = 0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0; s0_axis_tuser = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0; s1_axis_tuser = 1'b0;
    forever begin
      @(negedge clk);
      hs0 = s0_axis_tvalid && s0_axis_tready;
      hs1 = s1_axis_tvalid && s1_axis_tready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s0_axis_tvalid = 1'b1; s0_axis_tdata = rnd_data(); s0_axis_tkeep = '1; s0_axis_tlast = 1'b1; s0_axis_tuser = 1'b1;
        s1_axis_tvalid = 1'b1; s1_axis_tdata = rnd_data(); s1_axis_tkeep = '1; s1_axis_tlast = 1'b1; s1_axis_tuser = 1'b1;
      end else begin
        if (hs0 && drv_q0.size() > 0) begin
          void'(drv_q0.pop_front());
          if (gaps_en && drv_q0.size() > 0 && !drv_q0[0].first) gap0 = $urandom_range(0, 2);
        end
        if (hs1 && drv_q1.size() > 0) begin
          void'(drv_q1.pop_front());
          if (gaps_en && drv_q1.size() > 0 && !drv_q1[0].first) gap1 = $urandom_range(0, 2);
        end
        if (gap0 > 0) begin s0_axis_tvalid = 1'b0; gap0--; end
        else if (drv_q0.size() > 0) begin
          s0_axis_tvalid = 1'b1;
          s0_axis_tdata  = drv_q0[0].data; s0_axis_tkeep = drv_q0[0].keep;
          s0_axis_tlast  = drv_q0[0].last; s0_axis_tuser = drv_q0[0].user;
        end else s0_axis_tvalid = 1'b0;
        if (gap1 > 0) begin s1_axis_tvalid = 1'b0; gap1--; end
        else if (drv_q1.size() > 0) begin
          s1_axis_tvalid = 1'b1;
          s1_axis_tdata  = drv_q1[0].data; s1_axis_tkeep = drv_q1[0].keep;
          s1_axis_tlast  = drv_q1[0].last; s1_axis_tuser = drv_q1[0].user;
        end else s1_axis_tvalid = 1'b0;
      end
    end
  end

  // Downstream ready: 0 = always, 1 = toggle, 2 = random (75%).
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: the only process that steps vectors/errors.
  initial begin
    exp_t       e;
    logic [1:0] tr_need;
    int         cyc, last_end;
    bit         tmo_seen, stats_done;
    cyc = 0; last_end = -1; tmo_seen = 0; stats_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!chk_gap) last_end = -1;
      if (chk_reset) begin
        vectors++;
        if (m_axis_tvalid || s0_axis_tready || s1_axis_tready || o_busy || o_trunc_pulse != 2'b00 ||
            m_axis_tdata != '0 || m_axis_tkeep != '0 || m_axis_tlast || m_axis_tuser) begin
          errors++;
          $display("FAIL reset_outputs: got valid=%b rdy0=%b rdy1=%b busy=%b trunc=%b last=%b user=%b keep=%h, need all zero",
                   m_axis_tvalid, s0_axis_tready, s1_axis_tready, o_busy, o_trunc_pulse, m_axis_tlast, m_axis_tuser, m_axis_tkeep);
        end
      end else if (rst_n) begin
        if (m_axis_tvalid && m_axis_tready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data[63:0]=%h last=%b, need no beat", m_axis_tdata[63:0], m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            tr_need = e.trunc ? (e.ch ? 2'b10 : 2'b01) : 2'b00;
            if (m_axis_tdata !== e.b.data || m_axis_tkeep !== e.b.keep || m_axis_tlast !== e.last ||
                m_axis_tuser !== e.user || o_trunc_pulse !== tr_need ||
                s0_axis_tready !== ~e.ch || s1_axis_tready !== e.ch) begin
              errors++;
              $display("FAIL beat ch%0d: got data=%h keep=%h last=%b user=%b trunc=%b rdy=%b%b, need data=%h keep=%h last=%b user=%b trunc=%b rdy=%b%b",
                       e.ch, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, o_trunc_pulse, s1_axis_tready, s0_axis_tready,
                       e.b.data, e.b.keep, e.last, e.user, tr_need, e.ch, ~e.ch);
            end
            if (chk_gap && e.b.first && last_end >= 0) begin
              vectors++;
              if (cyc - last_end != 2) begin
                errors++;
                $display("FAIL pkt_gap: got %0d cycles between packets, need 2", cyc - last_end);
              end
            end
            if (e.last) last_end = cyc;
          end
        end else begin
          vectors++;
          if (o_trunc_pulse !== 2'b00) begin
            errors++;
            $display("FAIL trunc_no_beat: got trunc=%b, need 00", o_trunc_pulse);
          end
        end
        if (chk_idle) begin
          vectors++;
          if (m_axis_tvalid || s0_axis_tready || s1_axis_tready || o_busy) begin
            errors++;
            $display("FAIL no_grant: got valid=%b rdy0=%b rdy1=%b busy=%b, need 0 0 0 0",
                     m_axis_tvalid, s0_axis_tready, s1_axis_tready, o_busy);
          end
        end
`ifdef CMAC_TX_ARB_STATS_EN
        if (chk_stats && !stats_done) begin
          stats_done = 1;
          vectors += 3;
          if (o_pkt_cnt0 != 32'(m_pkt0)) begin errors++; $display("FAIL pkt_cnt0: got %0d, need %0d", o_pkt_cnt0, m_pkt0); end
          if (o_pkt_cnt1 != 32'(m_pkt1)) begin errors++; $display("FAIL pkt_cnt1: got %0d, need %0d", o_pkt_cnt1, m_pkt1); end
          if (o_drop_beats != 32'(m_drop)) begin errors++; $display("FAIL drop_beats: got %0d, need %0d", o_drop_beats, m_drop); end
        end
`endif
        if (tmo_fail && !tmo_seen) begin
          tmo_seen = 1;
          vectors++;
          errors++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  endtask

  task automatic timeout(input string what);
    $display("FAIL timeout_%s: got exp=%0d q0=%0d q1=%0d pending, need all drained", what, exp_q.size(), drv_q0.size(), drv_q1.size());
    tmo_fail = 1;
    step();
    step();
    summary_and_finish();
  endtask

  task automatic wait_done(input int budget, input string what);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || drv_q0.size() != 0 || drv_q1.size() != 0) && c < budget) begin
      step();
      c++;
    end
    if (exp_q.size() != 0 || drv_q0.size() != 0 || drv_q1.size() != 0) timeout(what);
  endtask

  task automatic idle_check(input int n);
    chk_idle = 1;
    repeat (n) step();
    chk_idle = 0;
  endtask

  initial begin
    int c;
    vectors = 0; errors = 0; m_lp = 1; m_pkt0 = 0; m_pkt1 = 0; m_drop = 0;
    rdy_mode = 0; gaps_en = 0; chk_reset = 0; chk_idle = 0; chk_gap = 0; chk_stats = 0; tmo_fail = 0;
    rst_n = 1'b0;
    link  = 1'b1;

    // Reset with every input active.
    repeat (2) step();
    chk_reset = 1;
    repeat (8) step();
    chk_reset = 0;

    // Link down: both requesters valid, nothing granted. Then round robin.
    rst_n = 1'b1;
    link  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pl0.push_back(4);
      pl1.push_back(4);
    end
    build();
    idle_check(6);
    link    = 1'b1;
    chk_gap = 1;
    wait_done(200, "rr");
    chk_gap = 0;
    idle_check(2);

    // Channel 1 alone with toggling downstream ready.
    rdy_mode = 1;
    pl1.push_back(5); pl1.push_back(3); pl1.push_back(6);
    build();
    wait_done(300, "toggle");
    rdy_mode = 0;
    idle_check(2);

    // Watchdog: 12-beat packet on ch0, then ch1, then MAXB and MAXB+1 lengths.
    pl0.push_back(12); pl0.push_back(MAXB); pl0.push_back(MAXB + 1);
    pl1.push_back(4);
    build();
    wait_done(300, "trunc");
    idle_check(2);

    // Link drops mid-packet: packet completes, no new grant until link returns.
    pl0.push_back(5);
    build();
    c = 0;
    while (exp_q.size() > 3 && c < 50) begin step(); c++; end
    if (exp_q.size() > 3) timeout("link_mid");
    link = 1'b0;
    pl1.push_back(3);
    build();
    c = 0;
    while ((exp_q.size() > 3 || drv_q0.size() != 0) && c < 50) begin step(); c++; end
    if (exp_q.size() > 3 || drv_q0.size() != 0) timeout("link_end");
    idle_check(8);
    link = 1'b1;
    wait_done(100, "link_up");
    idle_check(2);

    // Randomized rounds: bubbles, random ready, lengths across the watchdog limit.
    for (int r = 0; r < 6; r++) begin
      rdy_mode = 2;
      gaps_en  = 1;
      repeat ($urandom_range(0, 4)) pl0.push_back($urandom_range(1, 12));
      repeat ($urandom_range(0, 4)) pl1.push_back($urandom_range(1, 12));
      build();
      wait_done(3000, "random");
      gaps_en  = 0;
      rdy_mode = 0;
      idle_check(2);
    end

    chk_stats = 1;
    step();
    step();
    chk_stats = 0;
    step();
    summary_and_finish();
  end
endmodule
